// File: rtl/dem_mod_n.sv
// dem_mod_n: modulo-N up/down counter with synchronous load, wrap / saturate /
// one-shot behaviour and a combinational terminal-count output for cascading.
module dem_mod_n #(
   parameter int WIDTH = 4,
   parameter int MOD_N = 16,
   parameter int MODE  = 0
) (
   input  logic             ckht,
   input  logic             rst,
   input  logic             ena,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             done
);

   // Highest legal count; MOD_N may equal 2^WIDTH, so the modulus itself is
   // only ever handled in WIDTH+1 bits.
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD_N - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD_N);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             done_nxt;
   logic             at_term;
   logic             count_ok;

   // Out-of-range load values are clamped to the top of the count range.
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
      return ({1'b0, val} < MOD_EXT) ? val : Q_MAX;
   endfunction

   // Terminal detection, cascade output and the one-shot count gate.
   always_comb begin
      at_term  = up ? (q == Q_MAX) : (q == '0);
      tc       = ena & at_term;
      count_ok = (MODE != 2) || (state == ST_RUN);
   end

   // One-shot next-state logic; other modes stay parked in IDLE.
   always_comb begin
      state_nxt = state;
      if (MODE == 2) begin
         if (load)
            state_nxt = ST_RUN;
         else if (ena && (state == ST_RUN) && at_term)
            state_nxt = ST_DONE;
      end
   end

   // Next count, wrap pulse and done flag.
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      done_nxt = (MODE == 2) && (state_nxt == ST_DONE);
      if (load) begin
         q_nxt = clamp_load(d);
      end else if (ena && count_ok) begin
         if (!at_term) begin
            q_nxt = up ? (q + 1'b1) : (q - 1'b1);
         end else if (MODE == 0) begin
            q_nxt    = up ? '0 : Q_MAX;
            wrap_nxt = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge ckht) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Count and flag registers; reset wins over load and enable.
   always_ff @(posedge ckht) begin
      if (rst) begin
         q    <= '0;
         wrap <= 1'b0;
         done <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
         done <= done_nxt;
      end
   end

endmodule

// File: doc/dem_mod_n.md
# dem_mod_n

Parametrised modulo-N up/down counter with synchronous load, selectable wrap, saturate or one-shot mode, and a cascade terminal-count output. It is the general-purpose counter for the display and timing paths. Typical uses are scan counters, BCD digit chains built by feeding `tc` of one stage into `ena` of the next, and one-shot delay timers driven by a 1 kHz enable tick.

## Interface
- `WIDTH`, default 4, counter width in bits.
- `MOD_N`, default 16, count modulus. Legal range is 2..2^WIDTH. The count range is 0..MOD_N-1.
- `MODE`, default 0. 0 = wrap (free-running), 1 = saturate, 2 = one-shot.
- `ckht`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  count enable tick. The counter advances at most one step per cycle in which `ena`=1.
- `up`  in  1  direction. 1 = count up, 0 = count down. Sampled each cycle.
- `load`  in  1  synchronous load of `d`.
- `d`  in  WIDTH  load value.
- `q`  out  WIDTH  current count (registered).
- `tc`  out  1  terminal count (combinational). `tc` = `ena` & (`q`==MOD_N-1 when `up`=1, or `q`==0 when `up`=0).
- `wrap`  out  1  registered one-cycle pulse on a wrap event. MODE 0 only.
- `done`  out  1  registered one-shot completion flag. MODE 2 only; 0 in other modes.

## Operation
- Priority per cycle is `rst` > `load` > `ena`. When none is active, all state holds.
- Reset values: `q`=0, `wrap`=0, `done`=0, one-shot FSM state = IDLE.
- Load behaviour:
  - `q` <= `d` when `d` < MOD_N; otherwise `q` <= MOD_N-1 (clamped).
  - A load cycle never counts, even if `ena`=1.
  - `wrap` is 0 on a load cycle.
- Counting with `ena`=1 and not at the terminal: `q` <= `q`+1 when `up`=1, `q`-1 when `up`=0. All arithmetic is modulo MOD_N, never modulo 2^WIDTH.
- At the terminal (`q`==MOD_N-1 when up, `q`==0 when down) with `ena`=1:
  - MODE 0: `q` <= 0 (up) or MOD_N-1 (down); `wrap` <= 1 for one cycle.
  - MODE 1: `q` holds; `wrap` stays 0.
  - MODE 2: `q` holds; FSM moves RUN -> DONE.
- `tc` is valid in all modes. In MODE 1 it stays high every cycle that `ena`=1 while `q` sits at the terminal.
- One-shot FSM (MODE 2 only; MODES 0/1 always count):
  - IDLE: `ena` is ignored and `q` holds. `load` -> RUN.
  - RUN: counts as above. Terminal with `ena` -> DONE, `done` <= 1.
  - DONE: `q` is frozen and `done`=1. `ena` is ignored. `load` -> RUN, `done` <= 0, `q` <= `d`.
  - `rst` in any state -> IDLE, `q`=0, `done`=0.
- Direction change: a change on `up` affects the next enabled step only. No glitch or skip on `q`.
- MOD_N = 2^WIDTH must work; the terminal compare must not overflow.

## Timing
- Latency: `q` changes on the rising `ckht` edge that samples `ena`/`load`/`rst` high. Count latency is 1 cycle.
- `wrap` asserts on the same edge that `q` wraps and deasserts on the next edge, unless another wrap occurs.
- `done` asserts on the edge that enters DONE.
- `tc` is combinational from `q`, `up` and `ena`. There is no clock delay.
- Cascading: stage k+1 `ena` = stage k `tc`. Both stages update on the same edge. A chain of two MOD_N=10 stages counts 00..99.
- Reset during an active count takes effect on that edge. It overrides a simultaneous `load`/`ena`.

## Test plan
- MODE 0 wrap up: WIDTH=4, MOD_N=10, `up`=1, `ena`=1 every cycle after reset.
  - Required: `q` = 0,1,…,9,0.
  - `tc`=1 only while `q`=9.
  - `wrap`=1 for exactly the one cycle where `q`=0 after 9.
- MODE 0 wrap down: `up`=0 from reset.
  - Required: `q` = 0 -> 9 -> 8.
  - `wrap` pulses once on the 0->9 step.
  - Toggling `up` to 1 at `q`=8 gives next `q`=9.
- MODE 1 saturate: load `d`=7, then `ena`=1 for 5 cycles, `up`=1.
  - Required: `q` = 7,8,9,9,9,9.
  - `wrap` never asserts.
  - `tc`=1 on every cycle at 9.
- MODE 2 one-shot, part 1: after reset hold `ena`=1 with no `load`.
  - Required: `q` stays 0 and `done`=0.
- MODE 2 one-shot, part 2: load `d`=5 with `up`=1 and `ena`=1.
  - Required: `q` = 6,7,8,9, then `done`=1 with `q` held at 9.
  - A later `load` of `d`=2 gives `q`=2 and `done`=0, with counting resumed.
- Priority and clamp:
  - `load` `d`=12 together with `ena`=1 -> `q`=9 (clamped, no count).
  - `rst`+`load`+`ena` all high -> `q`=0.
  - `ena` pulsed 1-in-4 cycles -> `q` advances exactly once per 4 cycles.
  - Two-stage cascade (MOD_N=10 each) reaches 99 -> 00 with a single `wrap` on each stage.
